// File: rtl/dram_wr_rd_seq.sv
// dram_wr_rd_seq
//   Sequences one DRAM row operation per accepted start. The row address is
//   sent serially MSB first, then data is written, then the row is read back
//   and compared. The mode input selects write+read, write only or read only.
//
// States:
//   IDLE    | waiting for start; all strobes low
//   SHIFT_W | serial address shift ahead of a write (ADDR_W cycles)
//   WSETUP  | write data presented, one cycle before the enable
//   WRITE   | WRI_EN high for T_WR cycles
//   WRECOV  | one-cycle recovery; write-done flag raised on entry
//   SHIFT_R | serial address shift ahead of a read (ADDR_W cycles)
//   RDEN    | RD_EN only, T_SA cycles of bitline development
//   SENSE   | RD_EN and VSAEN for T_VS cycles; read data captured at the end
//   DONE    | one cycle; read-done and compare flags raised on entry
//
// Ports:
//   clk, rst_n (sync, active low), start, mode[1:0], cfg_addr, cfg_data,
//   DRAM16_data                                     -- inputs
//   ADD_IN, ADD_VALID_IN, D_IN, DATA_VALID_IN,
//   WRI_EN, RD_EN, VSAEN                             -- array interface
//   busy, WT_DONE_LED, RD_DONE_LED, mismatch, rd_data_q -- status
//
// Every output is registered and is computed from the next state, so an
// output changes on the same edge at which its state is entered.

module dram_wr_rd_seq #(
  parameter int ADDR_W = 6,
  parameter int T_WR   = 4,
  parameter int T_SA   = 3,
  parameter int T_VS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_data,
  input  logic [15:0]       DRAM16_data,
  output logic              ADD_IN,
  output logic              ADD_VALID_IN,
  output logic [15:0]       D_IN,
  output logic              DATA_VALID_IN,
  output logic              WRI_EN,
  output logic              RD_EN,
  output logic              VSAEN,
  output logic              busy,
  output logic              WT_DONE_LED,
  output logic              RD_DONE_LED,
  output logic              mismatch,
  output logic [15:0]       rd_data_q
);

  localparam int MAX_AW = (ADDR_W > T_WR) ? ADDR_W : T_WR;
  localparam int MAX_SV = (T_SA > T_VS) ? T_SA : T_VS;
  localparam int MAX_T  = (MAX_AW > MAX_SV) ? MAX_AW : MAX_SV;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  // Down-counter reload values: a phase of N cycles loads N-1 and ends at 0.
  localparam logic [CNT_W-1:0] LD_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LD_WR   = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] LD_SA   = CNT_W'(T_SA - 1);
  localparam logic [CNT_W-1:0] LD_VS   = CNT_W'(T_VS - 1);

  typedef enum logic [3:0] {
    IDLE, SHIFT_W, WSETUP, WRITE, WRECOV, SHIFT_R, RDEN, SENSE, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] sh_q, sh_d;
  logic [15:0]       data_q, data_d;
  logic              wr_only_q, wr_only_d;
  logic              add_in_d;
  logic              accept;
  logic              capture;
  logic              tc;

  assign tc = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tc ? cnt_q : cnt_q - 1'b1;
    addr_d    = addr_q;
    sh_d      = sh_q;
    data_d    = data_q;
    wr_only_d = wr_only_q;
    add_in_d  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          addr_d    = cfg_addr;
          data_d    = cfg_data;
          wr_only_d = (mode == 2'b01);
          // The first address bit goes out on the entry edge itself.
          add_in_d  = cfg_addr[ADDR_W-1];
          sh_d      = cfg_addr << 1;
          cnt_d     = LD_ADDR;
          state_d   = (mode == 2'b10) ? SHIFT_R : SHIFT_W;
        end
      end
      SHIFT_W: begin
        if (tc) begin
          state_d = WSETUP;
          cnt_d   = '0;
        end else begin
          add_in_d = sh_q[ADDR_W-1];
          sh_d     = sh_q << 1;
        end
      end
      WSETUP: begin
        state_d = WRITE;
        cnt_d   = LD_WR;
      end
      WRITE: begin
        if (tc) begin
          state_d = WRECOV;
          cnt_d   = '0;
        end
      end
      WRECOV: begin
        if (wr_only_q) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          // The shift register was consumed by the write pass; reload it
          // from the latched address for the read pass.
          state_d  = SHIFT_R;
          cnt_d    = LD_ADDR;
          add_in_d = addr_q[ADDR_W-1];
          sh_d     = addr_q << 1;
        end
      end
      SHIFT_R: begin
        if (tc) begin
          state_d = RDEN;
          cnt_d   = LD_SA;
        end else begin
          add_in_d = sh_q[ADDR_W-1];
          sh_d     = sh_q << 1;
        end
      end
      RDEN: begin
        if (tc) begin
          state_d = SENSE;
          cnt_d   = LD_VS;
        end
      end
      SENSE: begin
        if (tc) begin
          state_d = DONE;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      sh_q          <= '0;
      data_q        <= '0;
      wr_only_q     <= 1'b0;
      ADD_IN        <= 1'b0;
      ADD_VALID_IN  <= 1'b0;
      D_IN          <= '0;
      DATA_VALID_IN <= 1'b0;
      WRI_EN        <= 1'b0;
      RD_EN         <= 1'b0;
      VSAEN         <= 1'b0;
      busy          <= 1'b0;
      WT_DONE_LED   <= 1'b0;
      RD_DONE_LED   <= 1'b0;
      mismatch      <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      sh_q          <= sh_d;
      data_q        <= data_d;
      wr_only_q     <= wr_only_d;
      ADD_IN        <= add_in_d;
      ADD_VALID_IN  <= (state_d == SHIFT_W) || (state_d == SHIFT_R);
      DATA_VALID_IN <= (state_d == WSETUP) || (state_d == WRITE);
      D_IN          <= ((state_d == WSETUP) || (state_d == WRITE)) ? data_d : '0;
      WRI_EN        <= (state_d == WRITE);
      RD_EN         <= (state_d == RDEN) || (state_d == SENSE);
      VSAEN         <= (state_d == SENSE);
      busy          <= (state_d != IDLE);

      if (accept) begin
        WT_DONE_LED <= 1'b0;
        RD_DONE_LED <= 1'b0;
        mismatch    <= 1'b0;
      end
      if ((state_d == WRECOV) && (state_q != WRECOV))
        WT_DONE_LED <= 1'b1;
      // The compare uses the word being captured on this same edge, which is
      // exactly what rd_data_q holds during DONE.
      if (capture) begin
        rd_data_q   <= DRAM16_data;
        RD_DONE_LED <= 1'b1;
        mismatch    <= (DRAM16_data != data_q);
      end
    end
  end

endmodule

// File: tb/tb_dram_wr_rd_seq.sv
// tb_dram_wr_rd_seq
//   Directed bench for dram_wr_rd_seq with default parameters. Each operation
//   records a 30-cycle trace of every strobe (bit c = value during cycle c,
//   cycle 1 being the cycle after the edge that samples start) and compares
//   the traces with hand-derived cycle windows.

module tb_dram_wr_rd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [5:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] DRAM16_data;
  logic        ADD_IN, ADD_VALID_IN, DATA_VALID_IN, WRI_EN, RD_EN, VSAEN;
  logic        busy, WT_DONE_LED, RD_DONE_LED, mismatch;
  logic [15:0] D_IN, rd_data_q;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] tr_av, tr_ain, tr_dv, tr_we, tr_re, tr_vs, tr_busy, tr_wt, tr_rd, tr_mm;
  logic [15:0] tr_din [0:31];

  dram_wr_rd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .DRAM16_data(DRAM16_data),
    .ADD_IN(ADD_IN), .ADD_VALID_IN(ADD_VALID_IN), .D_IN(D_IN),
    .DATA_VALID_IN(DATA_VALID_IN), .WRI_EN(WRI_EN), .RD_EN(RD_EN),
    .VSAEN(VSAEN), .busy(busy), .WT_DONE_LED(WT_DONE_LED),
    .RD_DONE_LED(RD_DONE_LED), .mismatch(mismatch), .rd_data_q(rd_data_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] win(int lo, int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Expected serial address trace: MSB first starting at cycle off1, and
  // again at off2 when off2 is nonzero.
  function automatic logic [31:0] ain_exp(logic [5:0] a, int off1, int off2);
    logic [31:0] m = '0;
    for (int k = 0; k < 6; k++) begin
      m[off1 + k] = a[5 - k];
      if (off2 != 0) m[off2 + k] = a[5 - k];
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one operation at the next edge (edge 0) and traces cycles 1..30.
  // p1/p2: cycles in which an extra start pulse is driven; rst_cyc: cycle in
  // which rst_n is held low (0 = none).
  task automatic run_op(input logic [1:0] m, input logic [5:0] a, input logic [15:0] d,
                        input logic [15:0] rd, input int p1, input int p2, input int rst_cyc);
    mode = m; cfg_addr = a; cfg_data = d; DRAM16_data = rd;
    start = 1'b1; rst_n = 1'b1;
    {tr_av, tr_ain, tr_dv, tr_we, tr_re, tr_vs, tr_busy, tr_wt, tr_rd, tr_mm} = '0;
    for (int i = 0; i < 32; i++) tr_din[i] = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= 30; c++) begin
      start = (c == p1) || (c == p2);
      rst_n = (c != rst_cyc);
      @(negedge clk);
      tr_av[c] = ADD_VALID_IN;  tr_ain[c] = ADD_IN;   tr_dv[c] = DATA_VALID_IN;
      tr_we[c] = WRI_EN;        tr_re[c] = RD_EN;     tr_vs[c] = VSAEN;
      tr_busy[c] = busy;        tr_wt[c] = WT_DONE_LED;
      tr_rd[c] = RD_DONE_LED;   tr_mm[c] = mismatch;  tr_din[c] = D_IN;
      @(posedge clk); #1;
    end
    start = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; mode = 2'b00;
    cfg_addr = 6'h2D; cfg_data = 16'hA5A5; DRAM16_data = 16'hA5A5;

    // Reset with start asserted: reset wins, everything low.
    repeat (3) @(posedge clk);
    #1; @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_strobes", {26'b0, ADD_IN, ADD_VALID_IN, DATA_VALID_IN, WRI_EN, RD_EN, VSAEN}, 32'd0);
    chk("rst_flags", {29'b0, WT_DONE_LED, RD_DONE_LED, mismatch}, 32'd0);
    chk("rst_din", {16'b0, D_IN}, 32'd0);
    chk("rst_rdq", {16'b0, rd_data_q}, 32'd0);
    @(posedge clk); #1;

    // Mode 00, matching read; started in first cycle after reset release.
    run_op(2'b00, 6'h2D, 16'hA5A5, 16'hA5A5, 0, 0, 0);
    chk("m00_av",   tr_av,   win(1, 6) | win(13, 18));
    chk("m00_ain",  tr_ain,  ain_exp(6'h2D, 1, 13));
    chk("m00_dv",   tr_dv,   win(7, 11));
    chk("m00_we",   tr_we,   win(8, 11));
    chk("m00_re",   tr_re,   win(19, 23));
    chk("m00_vs",   tr_vs,   win(22, 23));
    chk("m00_wt",   tr_wt,   win(12, 30));
    chk("m00_rd",   tr_rd,   win(24, 30));
    chk("m00_busy", tr_busy, win(1, 24));
    chk("m00_mm",   tr_mm,   32'd0);
    chk("m00_excl", tr_we & tr_re, 32'd0);
    chk("m00_din6",  {16'b0, tr_din[6]},  32'd0);
    chk("m00_din7",  {16'b0, tr_din[7]},  32'h0000_A5A5);
    chk("m00_din11", {16'b0, tr_din[11]}, 32'h0000_A5A5);
    chk("m00_din12", {16'b0, tr_din[12]}, 32'd0);
    chk("m00_rdq",  {16'b0, rd_data_q}, 32'h0000_A5A5);

    // Mode 00, read data differs from written pattern.
    run_op(2'b00, 6'h13, 16'hA5A5, 16'h5A5A, 0, 0, 0);
    chk("mis_ain", tr_ain, ain_exp(6'h13, 1, 13));
    chk("mis_rd",  tr_rd,  win(24, 30));
    chk("mis_mm",  tr_mm,  win(24, 30));
    chk("mis_rdq", {16'b0, rd_data_q}, 32'h0000_5A5A);

    // Mode 01: write only; previous read flags must clear on start.
    run_op(2'b01, 6'h3F, 16'h1234, 16'hFFFF, 0, 0, 0);
    chk("m01_av",   tr_av,   win(1, 6));
    chk("m01_we",   tr_we,   win(8, 11));
    chk("m01_re",   tr_re,   32'd0);
    chk("m01_rd",   tr_rd,   32'd0);
    chk("m01_mm",   tr_mm,   32'd0);
    chk("m01_wt",   tr_wt,   win(12, 30));
    chk("m01_busy", tr_busy, win(1, 13));
    chk("m01_din8", {16'b0, tr_din[8]}, 32'h0000_1234);

    // Mode 10: read only.
    run_op(2'b10, 6'h21, 16'h0F0F, 16'h0F0F, 0, 0, 0);
    chk("m10_av",   tr_av,   win(1, 6));
    chk("m10_ain",  tr_ain,  ain_exp(6'h21, 1, 0));
    chk("m10_dv",   tr_dv,   32'd0);
    chk("m10_we",   tr_we,   32'd0);
    chk("m10_re",   tr_re,   win(7, 11));
    chk("m10_vs",   tr_vs,   win(10, 11));
    chk("m10_rd",   tr_rd,   win(12, 30));
    chk("m10_wt",   tr_wt,   32'd0);
    chk("m10_mm",   tr_mm,   32'd0);
    chk("m10_busy", tr_busy, win(1, 12));
    chk("m10_din7", {16'b0, tr_din[7]}, 32'd0);
    chk("m10_rdq",  {16'b0, rd_data_q}, 32'h0000_0F0F);

    // Mode 11 behaves as 00; extra start pulses at cycles 3 and 10 ignored.
    run_op(2'b11, 6'h2A, 16'hC3C3, 16'hC3C3, 3, 10, 0);
    chk("ign_av",   tr_av,   win(1, 6) | win(13, 18));
    chk("ign_ain",  tr_ain,  ain_exp(6'h2A, 1, 13));
    chk("ign_we",   tr_we,   win(8, 11));
    chk("ign_re",   tr_re,   win(19, 23));
    chk("ign_wt",   tr_wt,   win(12, 30));
    chk("ign_rd",   tr_rd,   win(24, 30));
    chk("ign_busy", tr_busy, win(1, 24));
    chk("ign_mm",   tr_mm,   32'd0);

    // Reset during WRITE (cycle 9): everything low from cycle 10.
    run_op(2'b00, 6'h15, 16'hFFFF, 16'hFFFF, 0, 0, 9);
    chk("rmid_we",   tr_we,   win(8, 9));
    chk("rmid_dv",   tr_dv,   win(7, 9));
    chk("rmid_busy", tr_busy, win(1, 9));
    chk("rmid_re",   tr_re,   32'd0);
    chk("rmid_wt",   tr_wt,   32'd0);
    chk("rmid_rd",   tr_rd,   32'd0);
    chk("rmid_din10", {16'b0, tr_din[10]}, 32'd0);
    chk("rmid_rdq",  {16'b0, rd_data_q}, 32'd0);

    // Full sequence after the aborted one.
    run_op(2'b00, 6'h0C, 16'h8001, 16'h8001, 0, 0, 0);
    chk("post_ain",  tr_ain,  ain_exp(6'h0C, 1, 13));
    chk("post_we",   tr_we,   win(8, 11));
    chk("post_re",   tr_re,   win(19, 23));
    chk("post_rd",   tr_rd,   win(24, 30));
    chk("post_busy", tr_busy, win(1, 24));
    chk("post_mm",   tr_mm,   32'd0);
    chk("post_rdq",  {16'b0, rd_data_q}, 32'h0000_8001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
